packet_stats_ctr: RTL

- Consumes the packet-length stream produced by the packet sensor: one 24-bit word per completed packet, formatted {port[7:0], length[15:0]}, with a tuser error flag.
- Accumulates per-port packet, byte and error counts in live counters.
- On request, atomically copies the live counters into snapshot registers and zeroes the live set. Software reads the snapshots through a simple one-cycle-latency read port.

---
 rtl/packet_stats_ctr.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/packet_stats_ctr.sv
// Per-port packet/byte/error statistics with atomic snapshot-and-clear and a registered read port.
// Define PKT_STATS_MAXLEN_EN to also track the per-port maximum packet length.
module packet_stats_ctr #(
    parameter int PORTS  = 4,
    parameter int PKT_W  = 32,
    parameter int BYTE_W = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] axis_in_tdata,
    input  logic        axis_in_tuser,
    input  logic        axis_in_tvalid,
    input  logic        snapshot_req,
    output logic        snapshot_done,
    input  logic        rd_req,
    input  logic [3:0]  rd_port,
    input  logic [1:0]  rd_sel,
    output logic [63:0] rd_data,
    output logic        rd_valid
);
    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t state, state_nxt;
    logic   capture;

    logic        vld_p1;
    logic [7:0]  port_p1;
    logic [15:0] len_p1;
    logic        err_p1;

    logic [PKT_W-1:0]  pkt_live  [PORTS];
    logic [PKT_W-1:0]  pkt_nxt   [PORTS];
    logic [PKT_W-1:0]  pkt_snap  [PORTS];
    logic [BYTE_W-1:0] byte_live [PORTS];
    logic [BYTE_W-1:0] byte_nxt  [PORTS];
    logic [BYTE_W-1:0] byte_snap [PORTS];
    logic [PKT_W-1:0]  err_live  [PORTS];
    logic [PKT_W-1:0]  err_nxt   [PORTS];
    logic [PKT_W-1:0]  err_snap  [PORTS];
`ifdef PKT_STATS_MAXLEN_EN
    logic [15:0]       max_live  [PORTS];
    logic [15:0]       max_nxt   [PORTS];
    logic [15:0]       max_snap  [PORTS];
`endif
    logic [PKT_W-1:0]  bad_live, bad_nxt, bad_snap;
    logic [63:0]       rd_mux;

    function automatic logic [PKT_W-1:0] sat_inc(input logic [PKT_W-1:0] v);
        return (&v) ? v : v + PKT_W'(1);
    endfunction

    function automatic logic [BYTE_W-1:0] sat_add(input logic [BYTE_W-1:0] v, input logic [15:0] len);
        logic [BYTE_W:0] sum;
        sum = {1'b0, v} + (BYTE_W+1)'(len);
        return sum[BYTE_W] ? '1 : sum[BYTE_W-1:0];
    endfunction

    // Stage 1: register the incoming word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            port_p1 <= '0;
            len_p1  <= '0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= axis_in_tvalid;
            if (axis_in_tvalid) begin
                port_p1 <= axis_in_tdata[23:16];
                len_p1  <= axis_in_tdata[15:0];
                err_p1  <= axis_in_tuser;
            end
        end
    end

    // Stage 2: read-modify-write of the addressed live counters
    always_comb begin
        bad_nxt = bad_live;
        if (vld_p1 && (port_p1 >= 8'(PORTS)))
            bad_nxt = sat_inc(bad_live);
        for (int p = 0; p < PORTS; p++) begin
            pkt_nxt[p]  = pkt_live[p];
            byte_nxt[p] = byte_live[p];
            err_nxt[p]  = err_live[p];
`ifdef PKT_STATS_MAXLEN_EN
            max_nxt[p]  = max_live[p];
`endif
            if (vld_p1 && (port_p1 == 8'(p))) begin
                pkt_nxt[p]  = sat_inc(pkt_live[p]);
                byte_nxt[p] = sat_add(byte_live[p], len_p1);
                if (err_p1)
                    err_nxt[p] = sat_inc(err_live[p]);
`ifdef PKT_STATS_MAXLEN_EN
                if (len_p1 > max_live[p])
                    max_nxt[p] = len_p1;
`endif
            end
        end
    end

    // The capture edge folds in any same-edge update, so nothing is lost across intervals
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_live <= '0;
            bad_snap <= '0;
            for (int p = 0; p < PORTS; p++) begin
                pkt_live[p]  <= '0;
                pkt_snap[p]  <= '0;
                byte_live[p] <= '0;
                byte_snap[p] <= '0;
                err_live[p]  <= '0;
                err_snap[p]  <= '0;
`ifdef PKT_STATS_MAXLEN_EN
                max_live[p]  <= '0;
                max_snap[p]  <= '0;
`endif
            end
        end else if (capture) begin
            bad_snap <= bad_nxt;
            bad_live <= '0;
            for (int p = 0; p < PORTS; p++) begin
                pkt_snap[p]  <= pkt_nxt[p];
                pkt_live[p]  <= '0;
                byte_snap[p] <= byte_nxt[p];
                byte_live[p] <= '0;
                err_snap[p]  <= err_nxt[p];
                err_live[p]  <= '0;
`ifdef PKT_STATS_MAXLEN_EN
                max_snap[p]  <= max_nxt[p];
                max_live[p]  <= '0;
`endif
            end
        end else begin
            bad_live <= bad_nxt;
            for (int p = 0; p < PORTS; p++) begin
                pkt_live[p]  <= pkt_nxt[p];
                byte_live[p] <= byte_nxt[p];
                err_live[p]  <= err_nxt[p];
`ifdef PKT_STATS_MAXLEN_EN
                max_live[p]  <= max_nxt[p];
`endif
            end
        end
    end

    // Snapshot FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snapshot_req) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture = (state == CAPTURE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            snapshot_done <= 1'b0;
        else
            snapshot_done <= capture;
    end

    // Read port: snapshot registers only, sampled before any same-edge capture
    always_comb begin
        rd_mux = '0;
        if ({1'b0, rd_port} >= 5'(PORTS)) begin
            if (rd_sel == 2'd3)
                rd_mux = 64'(bad_snap);
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (rd_port == 4'(p)) begin
                    case (rd_sel)
                        2'd0:    rd_mux = 64'(pkt_snap[p]);
                        2'd1:    rd_mux = 64'(byte_snap[p]);
                        2'd2:    rd_mux = 64'(err_snap[p]);
`ifdef PKT_STATS_MAXLEN_EN
                        default: rd_mux = 64'(max_snap[p]);
`else
                        default: rd_mux = '0;
`endif
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req)
                rd_data <= rd_mux;
        end
    end

endmodule
